// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter.
// The pipeline writeback always wins the write slot. Long-latency results are
// buffered in a FIFO and written back in slots the pipeline leaves idle. A
// starvation counter raises a stall request so that buffered results always
// retire.
// Optional feature macro: RF_WB_PENDING_EN adds the in-flight register query
// ports i_chk_addr / o_chk_pending.
module rf_wb_arbiter #(
  parameter int unsigned  DEPTH     = 4,
  parameter int unsigned  MAX_STALL = 8,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pipe_wren,
  input  logic [4:0]       i_pipe_rd_addr,
  input  logic [31:0]      i_pipe_rd_data,
  input  logic             i_lu_valid,
  output logic             o_lu_ready,
  input  logic [4:0]       i_lu_rd_addr,
  input  logic [31:0]      i_lu_rd_data,
  output logic             o_rd_wren,
  output logic [4:0]       o_rd_addr,
  output logic [31:0]      o_rd_data,
  output logic             o_pipe_stall,
  output logic [CNT_W-1:0] o_fifo_count,
  output logic             o_fifo_full,
  output logic             o_fifo_empty
`ifdef RF_WB_PENDING_EN
  ,
  input  logic [4:0]       i_chk_addr,
  output logic             o_chk_pending
`endif
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned SCNT_W = $clog2(MAX_STALL + 1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t               mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_next;
  logic [SCNT_W-1:0]       stall_cnt;
  logic [SCNT_W-1:0]       stall_cnt_next;
  logic                    stall_q;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pipe_take;
  logic                    lu_hs;
  logic                    push;
  logic                    pop;

  // FIFO occupancy flags come straight from the count register.
  assign fifo_full    = (count == CNT_W'(DEPTH));
  assign fifo_empty   = (count == '0);
  assign o_fifo_full  = fifo_full;
  assign o_fifo_empty = fifo_empty;
  assign o_fifo_count = count;
  assign o_pipe_stall = stall_q;

  // Ready is held low during reset and whenever the FIFO is full.
  assign o_lu_ready = i_rst && !fifo_full;

  // Slot selection: a pipeline write to x0 leaves the slot free for the FIFO.
  assign pipe_take = i_pipe_wren && (i_pipe_rd_addr != 5'd0);
  assign pop       = !pipe_take && !fifo_empty;
  assign lu_hs     = i_lu_valid && o_lu_ready;
  assign push      = lu_hs && (i_lu_rd_addr != 5'd0);

  // Next occupancy and starvation counter values.
  always_comb begin
    count_next     = count;
    stall_cnt_next = stall_cnt;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
    if (pop || fifo_empty) begin
      stall_cnt_next = '0;
    end else if (pipe_take && (stall_cnt != SCNT_W'(MAX_STALL))) begin
      stall_cnt_next = stall_cnt + SCNT_W'(1);
    end
  end

  // FIFO pointers, occupancy and starvation state.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      stall_cnt <= '0;
      stall_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count     <= count_next;
      stall_cnt <= stall_cnt_next;
      stall_q   <= (stall_cnt_next == SCNT_W'(MAX_STALL));
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= '{addr: i_lu_rd_addr, data: i_lu_rd_data};
    end
  end

  // Registered register-file write port; address/data hold on idle slots.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_rd_wren <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
    end else begin
      o_rd_wren <= pipe_take || pop;
      if (pipe_take) begin
        o_rd_addr <= i_pipe_rd_addr;
        o_rd_data <= i_pipe_rd_data;
      end else if (pop) begin
        o_rd_addr <= mem[rd_ptr].addr;
        o_rd_data <= mem[rd_ptr].data;
      end
    end
  end

`ifdef RF_WB_PENDING_EN
  // In-flight query: any occupied FIFO slot or the accepted handshake this cycle.
  always_comb begin
    logic [PTR_W-1:0] offs;
    logic             hit;
    offs = '0;
    hit  = lu_hs && (i_lu_rd_addr == i_chk_addr);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr;
      if ((CNT_W'(offs) < count) && (mem[PTR_W'(i)].addr == i_chk_addr)) begin
        hit = 1'b1;
      end
    end
    o_chk_pending = hit && (i_chk_addr != 5'd0);
  end
`endif

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Drives the register-file write port (wren/rd_addr/rd_data) from two producers.
- Pipeline writeback: single-cycle, cannot be back-pressured, highest priority.
- Long-latency unit (mul/div, load miss): valid/ready handshake, results buffered in an internal FIFO and drained into idle write slots.
- A starvation counter requests a one-cycle pipeline stall so buffered results always retire.

Parameters:
DEPTH, 4, long-latency result FIFO entries (power of two, >=2)
MAX_STALL, 8, consecutive pipeline-won cycles with a non-empty FIFO before o_pipe_stall asserts
CNT_W, $clog2(DEPTH+1), width of o_fifo_count (derived, not overridden)

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  reset, synchronous, active-low
i_pipe_wren  in  1  pipeline writeback request
i_pipe_rd_addr  in  5  pipeline destination register
i_pipe_rd_data  in  32  pipeline writeback data
i_lu_valid  in  1  long-latency result valid
o_lu_ready  out  1  FIFO can accept; transfer when valid&&ready
i_lu_rd_addr  in  5  long-latency destination register
i_lu_rd_data  in  32  long-latency result data
o_rd_wren  out  1  register-file write enable (registered)
o_rd_addr  out  5  register-file write address (registered)
o_rd_data  out  32  register-file write data (registered)
o_pipe_stall  out  1  upstream must not assert i_pipe_wren next cycle
o_fifo_count  out  CNT_W  entries currently buffered
o_fifo_full  out  1  count==DEPTH
o_fifo_empty  out  1  count==0

Behaviour:
- Reset (i_rst low at posedge):
  - o_rd_wren=0, o_rd_addr=0, o_rd_data=0.
  - FIFO pointers and count = 0.
  - Starvation counter = 0, o_pipe_stall=0.
  - o_lu_ready=0 while i_rst low (o_lu_ready = i_rst && !o_fifo_full).
- Reset mid-operation discards all buffered entries; no write issues in the cycle after reset.
- Slot selection each cycle, registered onto o_rd_* at next posedge:
  1. Pipeline write: i_pipe_wren && i_pipe_rd_addr!=0, outputs pipe addr/data.
  2. Else, if FIFO non-empty: pop head and output its addr/data.
  3. Else o_rd_wren=0; o_rd_addr/o_rd_data hold their previous values.
- Pipeline write to x0 is a no-slot cycle, so the FIFO may pop that cycle.
- Latency:
  - Pipeline: 1 cycle from request to o_rd_wren.
  - Long-latency: minimum 2 cycles from handshake (enqueue edge, then pop edge). No bypass path.
- FIFO push: on i_lu_valid && o_lu_ready with i_lu_rd_addr!=0.
  - Handshake with addr 0 completes but the entry is dropped and count is unchanged.
- o_lu_ready depends only on full. When full, push is refused even if a pop occurs the same cycle.
- Simultaneous push and pop when not full: count unchanged, order preserved.
- Pointers wrap modulo DEPTH; strict FIFO order.
- Starvation counter, saturating at MAX_STALL:
  - Increments when FIFO non-empty and the pipeline takes the slot.
  - Clears on any FIFO pop or when the FIFO is empty.
- o_pipe_stall = (counter==MAX_STALL), driven from the register.
  - Upstream honours it by holding i_pipe_wren=0 for that cycle; the FIFO then pops and the counter clears.
  - If upstream violates it, the pipeline still wins, the counter stays saturated and the stall remains asserted.
- Same-register ordering between producers is issue logic's responsibility. The arbiter does not reorder or merge.

Optional Feature:
Macro RF_WB_PENDING_EN.
- Defined: adds ports i_chk_addr (in, 5) and o_chk_pending (out, 1).
  - o_chk_pending is combinational: 1 iff any valid FIFO entry, or a same-cycle accepted long-latency handshake, targets i_chk_addr.
  - i_chk_addr==0 always gives 0.
  - Used by hazard logic to stall reads of registers still in flight.
- Undefined: ports absent, no per-entry compare logic.

Test Plan:
- Reset: hold i_rst=0 for 3 cycles with i_lu_valid=1 -> o_lu_ready=0, o_rd_wren=0, o_fifo_count=0. Release -> o_lu_ready=1.
- Pipeline only: wren addr=5 data=0xDEADBEEF -> next cycle o_rd_wren=1, addr=5, data=0xDEADBEEF. Addr=0 -> o_rd_wren=0.
- LU drain order: push (3,0x11), (4,0x22), (7,0x33) with pipeline idle -> writes appear in order 3,4,7 with 2-cycle first latency; count returns to 0.
- Full/back-pressure:
  - Pipeline busy every cycle; push 4 entries -> o_fifo_full=1, o_lu_ready=0, 5th valid held and not accepted.
  - Pipeline idles one cycle -> entry pops, ready=1.
- Starvation (MAX_STALL=8): FIFO holds 1 entry, pipeline writes 8 consecutive cycles -> o_pipe_stall=1. Upstream idles -> FIFO entry written, stall deasserts next cycle.
- RF_WB_PENDING_EN: entries to x9 and x12 buffered -> i_chk_addr=9 gives o_chk_pending=1, 10 gives 0, 0 gives 0. After x9 drains, 9 gives 0.
